// File: rtl/f_add_seq.sv
// f_add_seq: multi-cycle IEEE-754 single-precision adder.
// Operands are aligned, added and then normalised one leading-zero bit
// per cycle. The packed result is offered on a valid/ready output port.
// Rounding is by truncation. Denormal inputs and results are flushed to zero.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. in_ready is 1 only in IDLE, so A/B are
// sampled on that edge alone. out_valid is 1 only in DONE, and OUT_ADD
// stays stable until the transfer edge. OUT_ADD then keeps its value until
// the next result is produced or RST clears it.
module f_add_seq #(
  parameter int MAN_W = 23,
  parameter int EXP_W = 8
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   OUT_ADD
);

  localparam int DW = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 1;  // mantissa width including hidden bit

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic             r_sign;
  logic             r_sub;
  logic [EXP_W-1:0] r_exp;
  logic [MW-1:0]    r_ml;
  logic [MW-1:0]    r_ms;
  logic [MW:0]      r_sum;
  logic [DW-1:0]    r_out;

  // Alignment operands. A zero exponent means zero, so the whole
  // mantissa is cleared, not only the hidden bit.
  logic [EXP_W-1:0] w_ea;
  logic [EXP_W-1:0] w_eb;
  logic [MW-1:0]    w_ma;
  logic [MW-1:0]    w_mb;
  logic             w_a_big;
  logic [EXP_W-1:0] w_el;
  logic [EXP_W-1:0] w_es;
  logic [MW-1:0]    w_ml;
  logic [MW-1:0]    w_ms;
  logic [EXP_W-1:0] w_d;
  logic [MW-1:0]    w_ms_sh;

  // Normalisation helpers.
  logic             w_sum_zero;
  logic [EXP_W-1:0] w_exp_inc;
  logic             w_norm_done;

  assign w_ea    = r_a[DW-2 -: EXP_W];
  assign w_eb    = r_b[DW-2 -: EXP_W];
  assign w_ma    = (w_ea != '0) ? {1'b1, r_a[MAN_W-1:0]} : '0;
  assign w_mb    = (w_eb != '0) ? {1'b1, r_b[MAN_W-1:0]} : '0;
  assign w_a_big = ({w_ea, w_ma} >= {w_eb, w_mb});
  assign w_el    = w_a_big ? w_ea : w_eb;
  assign w_es    = w_a_big ? w_eb : w_ea;
  assign w_ml    = w_a_big ? w_ma : w_mb;
  assign w_ms    = w_a_big ? w_mb : w_ma;
  assign w_d     = w_el - w_es;
  assign w_ms_sh = (w_d >= EXP_W'(MW)) ? '0 : (w_ms >> w_d);

  assign w_sum_zero  = (r_sum == '0);
  assign w_exp_inc   = r_exp + EXP_W'(1);
  assign w_norm_done = w_sum_zero || r_sum[MW] || r_sum[MAN_W] ||
                       (r_exp == EXP_W'(1));

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign OUT_ADD   = r_out;

  // State register.
  always_ff @(posedge clk) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = ALIGN;
      ALIGN:   w_state_nxt = ADD;
      ADD:     w_state_nxt = NORM;
      NORM:    if (w_norm_done) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch, align, add, then normalise one step per cycle.
  always_ff @(posedge clk) begin
    if (RST) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sign <= 1'b0;
      r_sub  <= 1'b0;
      r_exp  <= '0;
      r_ml   <= '0;
      r_ms   <= '0;
      r_sum  <= '0;
      r_out  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a <= A;
            r_b <= B;
          end
        end
        ALIGN: begin
          r_ml   <= w_ml;
          r_ms   <= w_ms_sh;
          r_exp  <= w_el;
          r_sign <= w_a_big ? r_a[DW-1] : r_b[DW-1];
          r_sub  <= r_a[DW-1] ^ r_b[DW-1];
        end
        ADD: begin
          // L is the larger magnitude, so the difference is never negative.
          if (r_sub) r_sum <= {1'b0, r_ml} - {1'b0, r_ms};
          else       r_sum <= {1'b0, r_ml} + {1'b0, r_ms};
        end
        NORM: begin
          if (w_sum_zero) begin
            r_out <= '0;
          end else if (r_sum[MW]) begin
            r_sum <= r_sum >> 1;
            r_exp <= w_exp_inc;
            if (w_exp_inc == {EXP_W{1'b1}})
              r_out <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else
              r_out <= {r_sign, w_exp_inc, r_sum[MAN_W:1]};
          end else if (r_sum[MAN_W]) begin
            r_out <= {r_sign, r_exp, r_sum[MAN_W-1:0]};
          end else if (r_exp == EXP_W'(1)) begin
            r_out <= '0;
          end else begin
            r_sum <= r_sum << 1;
            r_exp <= r_exp - EXP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_f_add_seq.sv
// Directed testbench for f_add_seq. Latency is counted in rising edges,
// with the acceptance edge counted as edge 1.
module tb_f_add_seq;

  logic        clk;
  logic        RST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] OUT_ADD;

  int n_checks;
  int n_errors;

  f_add_seq dut (
    .clk       (clk),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT_ADD   (OUT_ADD)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one operand pair, wait for the result, and check the value
  // and latency. Returns in DONE at a falling edge with in_valid low.
  task automatic drive_and_wait(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] exp, input int exp_lat,
                                input string tag);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_value"}, OUT_ADD, exp);
  endtask

  // Full transaction with out_ready held high; also checks the return to
  // IDLE and that the result stays on OUT_ADD afterwards.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat,
                         input string tag);
    out_ready = 1'b1;
    drive_and_wait(a, b, exp, exp_lat, tag);
    @(negedge clk);
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_hold"}, OUT_ADD, exp);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    RST       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A         = '0;
    B         = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_add", OUT_ADD, 32'h0000_0000);

    // Main function.
    run_txn(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4,  "add_1p1");
    run_txn(32'h3FC0_0000, 32'hBF80_0000, 32'h3F00_0000, 5,  "lshift");
    run_txn(32'h4049_0FDB, 32'hC049_0FDB, 32'h0000_0000, 4,  "cancel");
    run_txn(32'h0000_0000, 32'hBF80_0000, 32'hBF80_0000, 4,  "zero_a");
    run_txn(32'h3F80_0000, 32'h3F00_0000, 32'h3FC0_0000, 4,  "add_1p05");
    run_txn(32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000, 4,  "ovf_inf");
    run_txn(32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 4,  "d24");
    run_txn(32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000, 27, "worst");

    // Backpressure: result held for 10 cycles, a stray in_valid is ignored.
    out_ready = 1'b0;
    drive_and_wait(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4, "bp");
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 3);
      A        = 32'h4120_0000;
      B        = 32'h4120_0000;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_value_%0d", i), OUT_ADD, 32'h4000_0000);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_no_accept", 32'(in_ready), 32'd1);
    chk("bp_no_result", 32'(out_valid), 32'd0);

    // Reset while normalising a long left-shift sequence.
    A        = 32'h3F80_0001;
    B        = 32'hBF80_0000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(in_ready), 32'd0);
    RST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_add", OUT_ADD, 32'h0000_0000);
    run_txn(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 4, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
